core_sequencer: RTL and testbench

Multi-cycle control sequencer for the core: it generates the 3-bit `state` consumed by the decode stage and the rest of the datapath, and steps each instruction through FETCH, DECODE, EXEC, MEM and WRITE. It stretches EXEC for the variable-latency FPU and the I/O ports, and stretches MEM for data-memory handshakes. It also issues the one-cycle strobes (IR load, FPU start, PC/register-file write) and counts retired instructions.

---
 rtl/core_pkg.sv | 13 +
 rtl/seq_timeout.sv | 28 ++
 rtl/core_sequencer.sv | 132 +++++++++++++
 tb/tb_core_sequencer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared state encoding for the sequencer and decode stage
package core_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WRITE  = 3'd4,
    HALT   = 3'd5
  } state_t;

endpackage

// File: rtl/seq_timeout.sv
// rtl/seq_timeout.sv - FPU wait down-counter, loaded on EXEC entry, expired at zero
module seq_timeout #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= W'(TIMEOUT);
    end else if (en && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/core_sequencer.sv
// rtl/core_sequencer.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WRITE sequencer
// Optional SEQ_SKIP_MEM_EN: non-memory instructions go EXEC -> WRITE directly.
module core_sequencer
  import core_pkg::*;
#(
  parameter int FPU_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             halt_req,
  input  logic             imem_valid,
  input  logic             use_fpu,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             data_in,
  input  logic             data_out,
  input  logic             fpu_done,
  input  logic             dmem_ready,
  input  logic             rx_valid,
  input  logic             tx_ready,
  output logic [2:0]       state,
  output logic             imem_req,
  output logic             ir_we,
  output logic             fpu_start,
  output logic             dmem_req,
  output logic             rx_pop,
  output logic             tx_push,
  output logic             pc_we,
  output logic             rf_we,
  output logic [CNT_W-1:0] retired,
  output logic             fpu_err
);

  state_t state_q, state_d;
  logic   first_q;
  logic   exec_done;
  logic   fpu_timeout;
  logic   expired;
  logic   exec_entry;
  logic   mem_op;

  assign mem_op     = mem_read | mem_write;
  assign exec_entry = (state_d == EXEC) && (state_q != EXEC);

  seq_timeout #(.TIMEOUT(FPU_TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .load    (exec_entry),
    .en      (state_q == EXEC),
    .expired (expired)
  );

  always_comb begin
    state_d     = state_q;
    exec_done   = 1'b0;
    fpu_timeout = 1'b0;
    case (state_q)
      FETCH: begin
        if (halt_req)        state_d = HALT;
        else if (imem_valid) state_d = DECODE;
      end
      DECODE: state_d = EXEC;
      EXEC: begin
        // fpu_done in the entry cycle belongs to no launched operation
        if (use_fpu) begin
          if (!first_q) begin
            if (fpu_done) begin
              exec_done = 1'b1;
            end else if (expired) begin
              exec_done   = 1'b1;
              fpu_timeout = 1'b1;
            end
          end
        end else if (data_in) begin
          exec_done = rx_valid;
        end else if (data_out) begin
          exec_done = tx_ready;
        end else begin
          exec_done = 1'b1;
        end
        if (exec_done) begin
`ifdef SEQ_SKIP_MEM_EN
          state_d = mem_op ? MEM : WRITE;
`else
          state_d = MEM;
`endif
        end
      end
      MEM: begin
        if (!mem_op || dmem_ready) state_d = WRITE;
      end
      WRITE: state_d = FETCH;
      HALT: begin
        if (!halt_req) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  // Input-qualified strobes appear the cycle after their event; commit strobes line up with WRITE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= FETCH;
      first_q   <= 1'b0;
      ir_we     <= 1'b0;
      fpu_start <= 1'b0;
      rx_pop    <= 1'b0;
      tx_push   <= 1'b0;
      pc_we     <= 1'b0;
      rf_we     <= 1'b0;
      retired   <= '0;
      fpu_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      first_q   <= exec_entry;
      ir_we     <= (state_q == FETCH) && !halt_req && imem_valid;
      fpu_start <= (state_q == EXEC) && first_q && use_fpu;
      rx_pop    <= exec_done && !use_fpu && data_in;
      tx_push   <= exec_done && !use_fpu && !data_in && data_out;
      pc_we     <= (state_d == WRITE);
      rf_we     <= (state_d == WRITE);
      if (state_d == WRITE) retired <= retired + CNT_W'(1);
      fpu_err   <= fpu_err | fpu_timeout;
    end
  end

  assign state    = state_q;
  assign imem_req = (state_q == FETCH) && !halt_req;
  assign dmem_req = (state_q == MEM) && mem_op;

endmodule

// File: tb/tb_core_sequencer.sv
// tb/tb_core_sequencer.sv - table-driven and randomized bench for core_sequencer
module tb_core_sequencer;

  localparam int T  = 4;
  localparam int CW = 4;
`ifdef SEQ_SKIP_MEM_EN
  localparam int IDLE_M = 0;
`else
  localparam int IDLE_M = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic halt_req = 0, imem_valid = 0, use_fpu = 0, mem_read = 0, mem_write = 0;
  logic data_in = 0, data_out = 0, fpu_done = 0, dmem_ready = 0, rx_valid = 0, tx_ready = 0;
  logic [2:0] state;
  logic imem_req, ir_we, fpu_start, dmem_req, rx_pop, tx_push, pc_we, rf_we, fpu_err;
  logic [CW-1:0] retired;

  always #5 clk = ~clk;

  core_sequencer #(.FPU_TIMEOUT(T), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .halt_req(halt_req), .imem_valid(imem_valid),
    .use_fpu(use_fpu), .mem_read(mem_read), .mem_write(mem_write),
    .data_in(data_in), .data_out(data_out), .fpu_done(fpu_done),
    .dmem_ready(dmem_ready), .rx_valid(rx_valid), .tx_ready(tx_ready),
    .state(state), .imem_req(imem_req), .ir_we(ir_we), .fpu_start(fpu_start),
    .dmem_req(dmem_req), .rx_pop(rx_pop), .tx_push(tx_push), .pc_we(pc_we),
    .rf_we(rf_we), .retired(retired), .fpu_err(fpu_err)
  );

  typedef struct {
    int fpu, rd, wr, din, dout;
    int fd, k, rxd, txd, md;
  } instr_t;

  typedef struct {
    instr_t in;
    int     e, m, err;
  } vec_t;

  typedef struct {
    int f, e, m, total, fs, rxp, txp, dreq, err;
  } exp_t;

  typedef struct {
    int f, d, e, m, w, total, irw, irw_pos, fs, rxp, txp, pcw, pcw_pos, rfw, dreq, ireq;
  } meas_t;

  int checks = 0;
  int errors = 0;
  int exp_retired = 0;
  int exp_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Cycle counts follow directly from the per-state timing rules.
  function automatic exp_t model(instr_t i);
    exp_t x;
    bit mem;
    mem   = (i.rd != 0) || (i.wr != 0);
    x.f   = i.fd + 1;
    x.fs  = 0; x.rxp = 0; x.txp = 0; x.err = 0;
    if (i.fpu != 0) begin
      x.fs = 1;
      if (i.k >= 1 && i.k <= T) x.e = i.k + 1;
      else begin x.e = T + 1; x.err = 1; end
    end else if (i.din != 0) begin
      x.e = i.rxd + 1; x.rxp = 1;
    end else if (i.dout != 0) begin
      x.e = i.txd + 1; x.txp = 1;
    end else begin
      x.e = 1;
    end
    x.m     = mem ? i.md + 1 : IDLE_M;
    x.dreq  = mem ? i.md + 1 : 0;
    x.total = x.f + 1 + x.e + x.m + 1;
    return x;
  endfunction

  // Starts and ends at a falling edge with state in FETCH; drives responses by state-relative cycle.
  task automatic run_instr(input instr_t i, output meas_t r);
    int fi, ei, mi, cyc;
    bit seen_w;
    logic [2:0] st;
    fi = 0; ei = 0; mi = 0; seen_w = 0;
    r = '{default: 0};
    use_fpu = i.fpu[0]; mem_read = i.rd[0]; mem_write = i.wr[0];
    data_in = i.din[0]; data_out = i.dout[0];
    for (cyc = 0; cyc < 300; cyc++) begin
      st = state;
      if (st == 3'd0 && seen_w) break;
      if (ir_we)     begin r.irw++; r.irw_pos = cyc; end
      if (pc_we)     begin r.pcw++; r.pcw_pos = cyc; end
      if (rf_we)     r.rfw++;
      if (fpu_start) r.fs++;
      if (rx_pop)    r.rxp++;
      if (tx_push)   r.txp++;
      if (dmem_req)  r.dreq++;
      if (imem_req)  r.ireq++;
      imem_valid = 0; fpu_done = 0; rx_valid = 0; tx_ready = 0; dmem_ready = 0;
      case (st)
        3'd0: begin imem_valid = (fi >= i.fd); fi++; r.f++; end
        3'd1: r.d++;
        3'd2: begin
          fpu_done = (ei == i.k);
          rx_valid = (ei >= i.rxd);
          tx_ready = (ei >= i.txd);
          ei++; r.e++;
        end
        3'd3: begin dmem_ready = (mi >= i.md); mi++; r.m++; end
        3'd4: begin r.w++; seen_w = 1; end
        default: ;
      endcase
      @(negedge clk);
    end
    r.total = cyc;
    imem_valid = 1;
  endtask

  task automatic score(input string tag, input instr_t i, input meas_t r);
    exp_t x;
    x = model(i);
    exp_retired = (exp_retired + 1) % (1 << CW);
    exp_err = exp_err | x.err;
    check({tag, " fetch_cycles"}, r.f, x.f);
    check({tag, " decode_cycles"}, r.d, 1);
    check({tag, " mem_cycles"}, r.m, x.m);
    check({tag, " write_cycles"}, r.w, 1);
    check({tag, " total_cycles"}, r.total, x.total);
    check({tag, " ir_we_count"}, r.irw, 1);
    check({tag, " ir_we_pos"}, r.irw_pos, x.f);
    check({tag, " pc_we_count"}, r.pcw, 1);
    check({tag, " pc_we_pos"}, r.pcw_pos, x.total - 1);
    check({tag, " rf_we_count"}, r.rfw, 1);
    check({tag, " fpu_start_count"}, r.fs, x.fs);
    check({tag, " rx_pop_count"}, r.rxp, x.rxp);
    check({tag, " tx_push_count"}, r.txp, x.txp);
    check({tag, " dmem_req_cycles"}, r.dreq, x.dreq);
    check({tag, " imem_req_cycles"}, r.ireq, x.f);
    check({tag, " retired"}, retired, exp_retired);
    check({tag, " fpu_err"}, fpu_err, exp_err);
  endtask

  vec_t  vecs[$];
  meas_t r;
  instr_t ri;
  int    pc_seen;
  bit    bound_ok;

  initial begin
    // fpu rd wr din dout | fd k rxd txd md | exec mem err
    vecs.push_back('{'{0,0,0,0,0, 0,0,0,0,0}, 1, IDLE_M, 0});
    vecs.push_back('{'{1,0,0,0,0, 0,3,0,0,0}, 4, IDLE_M, 0});
    vecs.push_back('{'{1,0,0,0,0, 0,1,0,0,0}, 2, IDLE_M, 0});
    vecs.push_back('{'{1,0,0,0,0, 0,4,0,0,0}, 5, IDLE_M, 0});
    vecs.push_back('{'{0,1,0,0,0, 0,0,0,0,2}, 1, 3, 0});
    vecs.push_back('{'{0,0,1,0,0, 0,0,0,0,0}, 1, 1, 0});
    vecs.push_back('{'{0,0,0,1,0, 0,0,5,0,0}, 6, IDLE_M, 0});
    vecs.push_back('{'{0,0,0,0,1, 0,0,0,2,0}, 3, IDLE_M, 0});
    vecs.push_back('{'{1,0,0,1,0, 0,2,0,0,0}, 3, IDLE_M, 0});
    vecs.push_back('{'{0,0,0,1,1, 0,0,1,0,0}, 2, IDLE_M, 0});
    vecs.push_back('{'{0,1,1,0,0, 3,0,0,0,1}, 1, 2, 0});
    vecs.push_back('{'{1,0,0,0,0, 0,0,0,0,0}, 5, IDLE_M, 1});
    vecs.push_back('{'{1,1,0,0,0, 0,99,0,0,0}, 5, 1, 1});

    repeat (3) @(negedge clk);
    check("reset state", state, 0);
    check("reset ir_we", ir_we, 0);
    check("reset pc_we", pc_we, 0);
    check("reset dmem_req", dmem_req, 0);
    check("reset retired", retired, 0);
    check("reset fpu_err", fpu_err, 0);
    rst = 1;

    foreach (vecs[n]) begin
      run_instr(vecs[n].in, r);
      check($sformatf("v%0d exec_cycles", n), r.e, vecs[n].e);
      check($sformatf("v%0d mem_table", n), r.m, vecs[n].m);
      check($sformatf("v%0d err_table", n), fpu_err, vecs[n].err | exp_err);
      score($sformatf("v%0d", n), vecs[n].in, r);
    end

    // Reset in the middle of a stalled load
    use_fpu = 0; data_in = 0; data_out = 0; mem_read = 1; mem_write = 0;
    imem_valid = 1; dmem_ready = 0; pc_seen = 0; bound_ok = 0;
    for (int c = 0; c < 20; c++) begin
      if (pc_we) pc_seen++;
      if (state == 3'd3) begin bound_ok = 1; break; end
      @(negedge clk);
    end
    check("reached MEM", bound_ok, 1);
    @(negedge clk);
    if (pc_we) pc_seen++;
    check("mid-MEM dmem_req", dmem_req, 1);
    rst = 0;
    #1;
    check("abort state", state, 0);
    check("abort dmem_req", dmem_req, 0);
    check("abort retired", retired, 0);
    check("abort fpu_err", fpu_err, 0);
    check("abort no pc_we", pc_seen, 0);
    exp_retired = 0; exp_err = 0; mem_read = 0;
    @(negedge clk);
    rst = 1;

    // Halt requested in FETCH, released after a few cycles
    halt_req = 1;
    #1;
    check("halt imem_req", imem_req, 0);
    @(negedge clk);
    check("halt entered", state, 5);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("halt hold %0d", c), state, 5);
      check($sformatf("halt strobes %0d", c),
            {ir_we, fpu_start, rx_pop, tx_push, pc_we, rf_we, imem_req, dmem_req}, 0);
    end
    halt_req = 0;
    @(negedge clk);
    check("halt release", state, 0);

    for (int n = 0; n < 40; n++) begin
      ri.fpu  = ($urandom_range(0, 3) == 0);
      ri.rd   = $urandom_range(0, 1);
      ri.wr   = ($urandom_range(0, 3) == 0);
      ri.din  = ($urandom_range(0, 2) == 0);
      ri.dout = ($urandom_range(0, 2) == 0);
      ri.fd   = $urandom_range(0, 2);
      ri.k    = $urandom_range(1, T + 1);
      ri.rxd  = $urandom_range(0, 3);
      ri.txd  = $urandom_range(0, 3);
      ri.md   = $urandom_range(0, 3);
      run_instr(ri, r);
      score($sformatf("r%0d", n), ri, r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
